ttt_game_ctrl: RTL and testbench

Game-sequencing controller for the tic-tac-toe board. It consumes decoded keypad events, owns the 3x3 board state, alternates turns between O and X, and enforces an optional per-turn timeout. It detects wins and draws and exposes board, turn and result state to the dot-matrix and 7-segment display logic. It sits between the keypad scanner and the display blocks in the TTT top level.

---
 rtl/ttt_game_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the board, alternates turns,
// runs the per-turn timer and detects wins and draws.
module ttt_game_ctrl #(
  parameter int unsigned TURN_TIMEOUT = 500000000,
  parameter int unsigned ERR_HOLD     = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic        in_main,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  win_line,
  output logic [3:0]  move_count,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_MAIN,
    S_PLAY,
    S_CHECK,
    S_OVER
  } state_t;

  localparam bit LP_TMR_EN = (TURN_TIMEOUT != 0);
  localparam logic [31:0] LP_TO_LAST =
    LP_TMR_EN ? 32'(TURN_TIMEOUT - 1) : 32'd0;
  localparam logic [31:0] LP_ERR_LD = 32'(ERR_HOLD);

  // Cell triples for rows, columns, main and anti diagonal.
  localparam int unsigned LN [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  state_t      r_state;
  logic [17:0] r_board;
  logic        r_turn;
  logic [1:0]  r_winner;
  logic [2:0]  r_wline;
  logic [3:0]  r_mc;
  logic [31:0] r_errc;
  logic        r_err;
  logic [31:0] r_tmr;
  logic        r_to;
  logic        r_in_main;
  logic        r_over;

  state_t      w_state_n;
  logic [17:0] w_board_n;
  logic        w_turn_n;
  logic [1:0]  w_winner_n;
  logic [2:0]  w_wline_n;
  logic [3:0]  w_mc_n;
  logic [31:0] w_errc_n;
  logic [31:0] w_tmr_n;
  logic        w_to_n;

  logic        w_key_start;
  logic        w_key_abort;
  logic        w_key_cell;
  logic        w_cell_occ;
  logic [1:0]  w_mark;
  logic [1:0]  w_cell [9];
  logic        w_win;
  logic [1:0]  w_win_mark;
  logic [2:0]  w_win_line;
  logic        w_tmr_exp;

  for (genvar g = 0; g < 9; g++) begin : g_cell
    assign w_cell[g] = r_board[2*g +: 2];
  end

  assign w_key_start = key_valid && (key_code == 4'd10);
  assign w_key_abort = key_valid && (key_code == 4'd11);
  assign w_key_cell  = key_valid && (key_code >= 4'd1)
                     && (key_code <= 4'd9);
  assign w_mark      = r_turn ? 2'd2 : 2'd1;
  assign w_tmr_exp   = LP_TMR_EN && (r_tmr == LP_TO_LAST);

  // Occupancy of the cell addressed by the current key.
  always_comb begin
    w_cell_occ = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (key_code == 4'(i + 1)) begin
        w_cell_occ = (w_cell[i] != 2'd0);
      end
    end
  end

  // Scan lines high to low so the lowest matching index wins.
  always_comb begin
    w_win      = 1'b0;
    w_win_mark = 2'd0;
    w_win_line = 3'd0;
    for (int l = 7; l >= 0; l--) begin
      if ((w_cell[LN[l][0]] != 2'd0)
          && (w_cell[LN[l][0]] == w_cell[LN[l][1]])
          && (w_cell[LN[l][1]] == w_cell[LN[l][2]])) begin
        w_win      = 1'b1;
        w_win_mark = w_cell[LN[l][0]];
        w_win_line = 3'(l);
      end
    end
  end

  // Next-state and next-output logic; '#' overrides everything.
  always_comb begin
    w_state_n  = r_state;
    w_board_n  = r_board;
    w_turn_n   = r_turn;
    w_winner_n = r_winner;
    w_wline_n  = r_wline;
    w_mc_n     = r_mc;
    w_tmr_n    = r_tmr;
    w_to_n     = 1'b0;
    w_errc_n   = (r_errc != 32'd0) ? r_errc - 32'd1 : 32'd0;
    if (w_key_abort) begin
      w_state_n  = S_MAIN;
      w_board_n  = 18'd0;
      w_turn_n   = 1'b1;
      w_winner_n = 2'd0;
      w_wline_n  = 3'd0;
      w_mc_n     = 4'd0;
      w_errc_n   = 32'd0;
      w_tmr_n    = 32'd0;
    end else begin
      unique case (r_state)
        S_MAIN, S_OVER: begin
          if (w_key_start) begin
            w_state_n  = S_PLAY;
            w_board_n  = 18'd0;
            w_turn_n   = 1'b1;
            w_winner_n = 2'd0;
            w_wline_n  = 3'd0;
            w_mc_n     = 4'd0;
            w_tmr_n    = 32'd0;
          end
        end
        S_PLAY: begin
          if (w_key_cell && !w_cell_occ) begin
            for (int i = 0; i < 9; i++) begin
              if (key_code == 4'(i + 1)) begin
                w_board_n[2*i +: 2] = w_mark;
              end
            end
            w_mc_n    = r_mc + 4'd1;
            w_errc_n  = 32'd0;
            w_tmr_n   = 32'd0;
            w_state_n = S_CHECK;
          end else begin
            if (w_key_cell) begin
              w_errc_n = LP_ERR_LD;
            end
            if (w_tmr_exp) begin
              w_turn_n = ~r_turn;
              w_tmr_n  = 32'd0;
              w_to_n   = 1'b1;
            end else if (LP_TMR_EN) begin
              w_tmr_n = r_tmr + 32'd1;
            end
          end
        end
        S_CHECK: begin
          if (w_win) begin
            w_state_n  = S_OVER;
            w_winner_n = w_win_mark;
            w_wline_n  = w_win_line;
          end else if (r_mc == 4'd9) begin
            w_state_n  = S_OVER;
            w_winner_n = 2'd3;
            w_wline_n  = 3'd0;
          end else begin
            w_state_n = S_PLAY;
            w_turn_n  = ~r_turn;
            w_tmr_n   = 32'd0;
          end
        end
        default: w_state_n = S_MAIN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_MAIN;
      r_board   <= 18'd0;
      r_turn    <= 1'b1;
      r_winner  <= 2'd0;
      r_wline   <= 3'd0;
      r_mc      <= 4'd0;
      r_errc    <= 32'd0;
      r_err     <= 1'b0;
      r_tmr     <= 32'd0;
      r_to      <= 1'b0;
      r_in_main <= 1'b1;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_board   <= w_board_n;
      r_turn    <= w_turn_n;
      r_winner  <= w_winner_n;
      r_wline   <= w_wline_n;
      r_mc      <= w_mc_n;
      r_errc    <= w_errc_n;
      r_err     <= (w_errc_n != 32'd0);
      r_tmr     <= w_tmr_n;
      r_to      <= w_to_n;
      r_in_main <= (w_state_n == S_MAIN);
      r_over    <= (w_state_n == S_OVER);
    end
  end

  assign board      = r_board;
  assign turn_o     = r_turn;
  assign in_main    = r_in_main;
  assign game_over  = r_over;
  assign winner     = r_winner;
  assign win_line   = r_wline;
  assign move_count = r_mc;
  assign err        = r_err;
  assign timeout    = r_to;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a short turn timer
// and short error hold so every path is reachable quickly.
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic        in_main;
  logic        game_over;
  logic [1:0]  winner;
  logic [2:0]  win_line;
  logic [3:0]  move_count;
  logic        err;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  ttt_game_ctrl #(
    .TURN_TIMEOUT(8),
    .ERR_HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .board(board),
    .turn_o(turn_o),
    .in_main(in_main),
    .game_over(game_over),
    .winner(winner),
    .win_line(win_line),
    .move_count(move_count),
    .err(err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic mv(input logic [3:0] c);
    press(c);
    tick(1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_main"}, in_main, 1);
    chk({p, "_board"}, board, 0);
    chk({p, "_turn"}, turn_o, 1);
    chk({p, "_over"}, game_over, 0);
    chk({p, "_winner"}, winner, 0);
    chk({p, "_line"}, win_line, 0);
    chk({p, "_mc"}, move_count, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_to"}, timeout, 0);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    tick(2);
    chk_reset("rst");
    rst = 1'b0;

    press(4'd10);
    chk("start_in_main", in_main, 0);
    chk("start_board", board, 0);
    chk("start_turn", turn_o, 1);
    press(4'd5);
    chk("m1_board", board, 512);
    chk("m1_turn_hold", turn_o, 1);
    chk("m1_mc", move_count, 1);
    tick(1);
    chk("m1_turn", turn_o, 0);
    chk("m1_over", game_over, 0);

    press(4'd5);
    chk("ill_err", err, 1);
    chk("ill_board", board, 512);
    chk("ill_turn", turn_o, 0);
    tick(3);
    chk("ill_err_last", err, 1);
    tick(1);
    chk("ill_err_off", err, 0);
    tick(2);
    chk("to_pre", timeout, 0);
    chk("to_pre_turn", turn_o, 0);
    tick(1);
    chk("to_pulse", timeout, 1);
    chk("to_turn", turn_o, 1);
    chk("to_board", board, 512);
    chk("to_mc", move_count, 1);
    tick(1);
    chk("to_one_cyc", timeout, 0);
    tick(6);
    press(4'd1);
    chk("col_to", timeout, 0);
    chk("col_board", board, 514);
    chk("col_mc", move_count, 2);
    tick(1);
    chk("col_turn", turn_o, 0);
    tick(7);
    press(4'd1);
    chk("colill_to", timeout, 1);
    chk("colill_err", err, 1);
    chk("colill_turn", turn_o, 1);
    chk("colill_board", board, 514);

    mv(4'd2);
    mv(4'd3);
    chk("m4_board", board, 538);
    chk("m4_mc", move_count, 4);
    press(4'd1);
    chk("m4_err", err, 1);
    press(4'd11);
    chk("abort_in_main", in_main, 1);
    chk("abort_board", board, 0);
    chk("abort_mc", move_count, 0);
    chk("abort_err", err, 0);
    chk("abort_turn", turn_o, 1);

    press(4'd10);
    mv(4'd1);
    mv(4'd4);
    mv(4'd2);
    mv(4'd5);
    press(4'd3);
    chk("row_lat", game_over, 0);
    chk("row_board", board, 362);
    tick(1);
    chk("row_over", game_over, 1);
    chk("row_winner", winner, 2);
    chk("row_line", win_line, 0);
    chk("row_mc", move_count, 5);
    press(4'd6);
    press(4'd7);
    chk("frz_board", board, 362);
    chk("frz_mc", move_count, 5);
    chk("frz_over", game_over, 1);

    press(4'd10);
    chk("rst2_over", game_over, 0);
    chk("rst2_winner", winner, 0);
    chk("rst2_board", board, 0);
    chk("rst2_turn", turn_o, 1);
    mv(4'd3);
    mv(4'd1);
    mv(4'd5);
    mv(4'd2);
    mv(4'd7);
    chk("anti_winner", winner, 2);
    chk("anti_line", win_line, 7);

    press(4'd10);
    mv(4'd1);
    mv(4'd2);
    mv(4'd3);
    mv(4'd5);
    mv(4'd4);
    mv(4'd8);
    chk("colx_winner", winner, 1);
    chk("colx_line", win_line, 4);
    chk("colx_mc", move_count, 6);

    press(4'd10);
    mv(4'd5);
    mv(4'd1);
    mv(4'd9);
    mv(4'd3);
    mv(4'd2);
    mv(4'd8);
    mv(4'd4);
    mv(4'd6);
    mv(4'd7);
    chk("draw_winner", winner, 3);
    chk("draw_mc", move_count, 9);
    chk("draw_line", win_line, 0);
    chk("draw_over", game_over, 1);
    chk("draw_board", board, 157337);

    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd10;
    tick(1);
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    chk_reset("rst_over");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
